// File: rtl/bus_arbiter_pkg.sv
// Shared definitions for the bus arbiter: grant-policy encodings, transfer
// counter width and the saturating counter helper.
package bus_arbiter_pkg;

    localparam int ARB_FIXED  = 0;
    localparam int ARB_RR     = 1;

    localparam int XFER_CNT_W = 16;
    localparam logic [XFER_CNT_W-1:0] XFER_CNT_MAX = 16'hFFFF;

    // Increment that sticks at the all-ones value instead of wrapping.
    function automatic logic [XFER_CNT_W-1:0] sat_inc(input logic [XFER_CNT_W-1:0] v);
        logic [XFER_CNT_W-1:0] r;
        if (v == XFER_CNT_MAX) begin
            r = v;
        end else begin
            r = v + 16'd1;
        end
        return r;
    endfunction

endpackage

// File: rtl/bus_arbiter_if.sv
// Bus arbiter signal bundle. The master side drives source data, the
// active-low drive requests and the contention clear; the slave side (the
// arbiter) returns the registered bus, grant and status.
interface bus_arbiter_if
    import bus_arbiter_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int N_SRC = 4
) ();

    logic [N_SRC*WIDTH-1:0] src_data;
    logic [N_SRC-1:0]       src_enable_n;
    logic                   contention_clr;
    logic [WIDTH-1:0]       bus_out;
    logic [N_SRC-1:0]       grant;
    logic                   bus_valid;
    logic                   contention;
    logic [XFER_CNT_W-1:0]  xfer_count;

    modport master (
        output src_data,
        output src_enable_n,
        output contention_clr,
        input  bus_out,
        input  grant,
        input  bus_valid,
        input  contention,
        input  xfer_count
    );

    modport slave (
        input  src_data,
        input  src_enable_n,
        input  contention_clr,
        output bus_out,
        output grant,
        output bus_valid,
        output contention,
        output xfer_count
    );

endinterface

// File: rtl/bus_arbiter_arb_pick.sv
// Combinational picker: scans the request vector starting at i_start,
// wrapping modulo N_SRC, and returns a one-hot grant for the first asserted
// request. An all-zero request vector yields an all-zero grant.
module arb_pick #(
    parameter int N_SRC = 4,
    parameter int IDX_W = $clog2(N_SRC)
) (
    input  logic [N_SRC-1:0] i_req,
    input  logic [IDX_W-1:0] i_start,
    output logic [N_SRC-1:0] o_grant
);

    localparam logic [IDX_W:0] NS = (IDX_W+1)'(N_SRC);

    logic [N_SRC-1:0] w_grant;
    logic [IDX_W:0]   w_raw;
    logic [IDX_W:0]   w_idx;
    logic             w_hit;
    logic             w_found;

    // Wrapping priority scan; each index is visited exactly once, so each
    // grant bit is written once and only the first hit can be set.
    always_comb begin
        w_grant = '0;
        w_found = 1'b0;
        w_raw   = '0;
        w_idx   = '0;
        w_hit   = 1'b0;
        for (int k = 0; k < N_SRC; k++) begin
            w_raw   = {1'b0, i_start} + (IDX_W+1)'(k);
            w_idx   = (w_raw >= NS) ? (w_raw - NS) : w_raw;
            w_hit   = ~w_found & i_req[w_idx[IDX_W-1:0]];
            w_grant[w_idx[IDX_W-1:0]] = w_hit;
            w_found = w_found | w_hit;
        end
    end

    assign o_grant = w_grant;

endmodule

// File: rtl/bus_arbiter.sv
// Bus arbiter top: samples active-low drive requests every clock, grants one
// source (fixed priority or round-robin), and registers the granted data,
// grant, valid, sticky contention flag and a saturating transfer counter.
module bus_arbiter
    import bus_arbiter_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int N_SRC = 4,
    parameter int MODE  = ARB_FIXED,
    parameter int KEEP  = 1
) (
    input  logic         clk,
    input  logic         reset_n,
    bus_arbiter_if.slave bus
);

    localparam int IDX_W = $clog2(N_SRC);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_SRC - 1);

    logic [N_SRC-1:0]      w_req;
    logic                  w_any;
    logic                  w_multi;
    logic [IDX_W-1:0]      w_start;
    logic [N_SRC-1:0]      w_grant;
    logic [IDX_W-1:0]      w_grant_idx;
    logic [WIDTH-1:0]      w_sel_data;

    logic [WIDTH-1:0]      r_bus_out;
    logic [N_SRC-1:0]      r_grant;
    logic                  r_bus_valid;
    logic                  r_contention;
    logic [XFER_CNT_W-1:0] r_xfer_count;
    logic [IDX_W-1:0]      r_last_grant;

    assign w_req   = ~bus.src_enable_n;
    assign w_any   = |w_req;
    // Clearing the lowest set bit leaves something only if two or more are set.
    assign w_multi = |(w_req & (w_req - N_SRC'(1)));

    // Search start: round-robin begins one past the last winner, fixed at 0.
    always_comb begin
        w_start = '0;
        if (MODE == ARB_RR) begin
            if (r_last_grant == LAST_IDX) begin
                w_start = '0;
            end else begin
                w_start = r_last_grant + IDX_W'(1);
            end
        end else begin
            w_start = '0;
        end
    end

    arb_pick #(
        .N_SRC (N_SRC),
        .IDX_W (IDX_W)
    ) u_arb_pick (
        .i_req   (w_req),
        .i_start (w_start),
        .o_grant (w_grant)
    );

    // One-hot grant to index and granted-slice select, done as AND-OR so the
    // one-hot guarantee makes both exact without priority logic.
    always_comb begin
        w_grant_idx = '0;
        w_sel_data  = '0;
        for (int i = 0; i < N_SRC; i++) begin
            w_grant_idx = w_grant_idx | (IDX_W'(i) & {IDX_W{w_grant[i]}});
            w_sel_data  = w_sel_data | (bus.src_data[i*WIDTH +: WIDTH] & {WIDTH{w_grant[i]}});
        end
    end

    // Registered arbitration result, round-robin pointer, sticky contention
    // and saturating transfer count.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_bus_out    <= '0;
            r_grant      <= '0;
            r_bus_valid  <= 1'b0;
            r_contention <= 1'b0;
            r_xfer_count <= '0;
            r_last_grant <= LAST_IDX;
        end else begin
            r_grant     <= w_grant;
            r_bus_valid <= w_any;
            if (w_any) begin
                r_bus_out    <= w_sel_data;
                r_last_grant <= w_grant_idx;
                r_xfer_count <= sat_inc(r_xfer_count);
            end else begin
                r_last_grant <= r_last_grant;
                r_xfer_count <= r_xfer_count;
                if (KEEP == 0) begin
                    r_bus_out <= '0;
                end else begin
                    r_bus_out <= r_bus_out;
                end
            end
            // A new multi-request outranks a clear in the same cycle.
            if (w_multi) begin
                r_contention <= 1'b1;
            end else if (bus.contention_clr) begin
                r_contention <= 1'b0;
            end else begin
                r_contention <= r_contention;
            end
        end
    end

    assign bus.bus_out    = r_bus_out;
    assign bus.grant      = r_grant;
    assign bus.bus_valid  = r_bus_valid;
    assign bus.contention = r_contention;
    assign bus.xfer_count = r_xfer_count;

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed bench for bus_arbiter: three instances share one stimulus stream
// (fixed/keep, round-robin/keep, fixed/zero-idle) and are checked against
// hand-computed values after each clock.
module tb_bus_arbiter;
    import bus_arbiter_pkg::*;

    localparam int W = 8;
    localparam int N = 4;

    logic         clk = 1'b0;
    logic         reset_n;
    logic [N*W-1:0] tb_data;
    logic [N-1:0] tb_en_n;
    logic         tb_clr;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    bus_arbiter_if #(.WIDTH(W), .N_SRC(N)) if_fix ();
    bus_arbiter_if #(.WIDTH(W), .N_SRC(N)) if_rr  ();
    bus_arbiter_if #(.WIDTH(W), .N_SRC(N)) if_k0  ();

    assign if_fix.src_data       = tb_data;
    assign if_fix.src_enable_n   = tb_en_n;
    assign if_fix.contention_clr = tb_clr;
    assign if_rr.src_data        = tb_data;
    assign if_rr.src_enable_n    = tb_en_n;
    assign if_rr.contention_clr  = tb_clr;
    assign if_k0.src_data        = tb_data;
    assign if_k0.src_enable_n    = tb_en_n;
    assign if_k0.contention_clr  = tb_clr;

    bus_arbiter #(.WIDTH(W), .N_SRC(N), .MODE(ARB_FIXED), .KEEP(1)) u_fix (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (if_fix)
    );

    bus_arbiter #(.WIDTH(W), .N_SRC(N), .MODE(ARB_RR), .KEEP(1)) u_rr (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (if_rr)
    );

    bus_arbiter #(.WIDTH(W), .N_SRC(N), .MODE(ARB_FIXED), .KEEP(0)) u_k0 (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (if_k0)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string name,
                           input logic [7:0] o_bus, input logic [3:0] o_gnt, input logic o_vld,
                           input logic o_cont, input logic [15:0] o_xc,
                           input logic [7:0] e_bus, input logic [3:0] e_gnt, input logic e_vld,
                           input logic e_cont, input logic [15:0] e_xc);
        chk({name, ".bus"},  {24'd0, o_bus}, {24'd0, e_bus});
        chk({name, ".gnt"},  {28'd0, o_gnt}, {28'd0, e_gnt});
        chk({name, ".vld"},  {31'd0, o_vld}, {31'd0, e_vld});
        chk({name, ".cont"}, {31'd0, o_cont}, {31'd0, e_cont});
        chk({name, ".xc"},   {16'd0, o_xc},  {16'd0, e_xc});
    endtask

    // One clock, then settle past the edge before anything is checked or driven.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    logic [3:0] rr_seq [6];
    logic [7:0] rr_bus [6];

    initial begin
        rr_seq[0] = 4'b0001; rr_seq[1] = 4'b0010; rr_seq[2] = 4'b0100;
        rr_seq[3] = 4'b1000; rr_seq[4] = 4'b0001; rr_seq[5] = 4'b0010;
        rr_bus[0] = 8'h11;   rr_bus[1] = 8'h22;   rr_bus[2] = 8'hA5;
        rr_bus[3] = 8'h44;   rr_bus[4] = 8'h11;   rr_bus[5] = 8'h22;

        // Reset state
        reset_n = 1'b0;
        tb_data = 32'h44332211;
        tb_en_n = 4'b1111;
        tb_clr  = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk_all("rst_fix", if_fix.bus_out, if_fix.grant, if_fix.bus_valid, if_fix.contention,
                if_fix.xfer_count, 8'h00, 4'b0000, 1'b0, 1'b0, 16'd0);
        chk_all("rst_rr", if_rr.bus_out, if_rr.grant, if_rr.bus_valid, if_rr.contention,
                if_rr.xfer_count, 8'h00, 4'b0000, 1'b0, 1'b0, 16'd0);

        // Sources 1 and 3 request: lowest wins, contention sets
        reset_n = 1'b1;
        tb_en_n = 4'b0101;
        step();
        chk_all("two_req_fix", if_fix.bus_out, if_fix.grant, if_fix.bus_valid, if_fix.contention,
                if_fix.xfer_count, 8'h22, 4'b0010, 1'b1, 1'b1, 16'd1);
        chk_all("two_req_rr", if_rr.bus_out, if_rr.grant, if_rr.bus_valid, if_rr.contention,
                if_rr.xfer_count, 8'h22, 4'b0010, 1'b1, 1'b1, 16'd1);

        // Clear together with a two-source request: set wins; rr resumes after src1
        tb_en_n = 4'b1100;
        tb_clr  = 1'b1;
        step();
        chk_all("clr_vs_set_fix", if_fix.bus_out, if_fix.grant, if_fix.bus_valid, if_fix.contention,
                if_fix.xfer_count, 8'h11, 4'b0001, 1'b1, 1'b1, 16'd2);
        chk_all("clr_vs_set_rr", if_rr.bus_out, if_rr.grant, if_rr.bus_valid, if_rr.contention,
                if_rr.xfer_count, 8'h11, 4'b0001, 1'b1, 1'b1, 16'd2);

        // Clear with a single request
        tb_en_n = 4'b1011;
        step();
        chk_all("clr_single_fix", if_fix.bus_out, if_fix.grant, if_fix.bus_valid, if_fix.contention,
                if_fix.xfer_count, 8'h33, 4'b0100, 1'b1, 1'b0, 16'd3);
        chk_all("clr_single_rr", if_rr.bus_out, if_rr.grant, if_rr.bus_valid, if_rr.contention,
                if_rr.xfer_count, 8'h33, 4'b0100, 1'b1, 1'b0, 16'd3);

        // Source 2 drives A5 once, then three idle cycles
        tb_clr  = 1'b0;
        tb_data = 32'h44A52211;
        step();
        chk_all("a5_fix", if_fix.bus_out, if_fix.grant, if_fix.bus_valid, if_fix.contention,
                if_fix.xfer_count, 8'hA5, 4'b0100, 1'b1, 1'b0, 16'd4);
        chk_all("a5_k0", if_k0.bus_out, if_k0.grant, if_k0.bus_valid, if_k0.contention,
                if_k0.xfer_count, 8'hA5, 4'b0100, 1'b1, 1'b0, 16'd4);
        tb_en_n = 4'b1111;
        for (int i = 0; i < 3; i++) begin
            step();
            chk_all("idle_keep1", if_fix.bus_out, if_fix.grant, if_fix.bus_valid, if_fix.contention,
                    if_fix.xfer_count, 8'hA5, 4'b0000, 1'b0, 1'b0, 16'd4);
            chk_all("idle_keep0", if_k0.bus_out, if_k0.grant, if_k0.bus_valid, if_k0.contention,
                    if_k0.xfer_count, 8'h00, 4'b0000, 1'b0, 1'b0, 16'd4);
        end

        // Mid-cycle reset with all requests active: outputs clear at once
        tb_en_n = 4'b0000;
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        chk_all("async_rst_fix", if_fix.bus_out, if_fix.grant, if_fix.bus_valid, if_fix.contention,
                if_fix.xfer_count, 8'h00, 4'b0000, 1'b0, 1'b0, 16'd0);
        chk_all("async_rst_rr", if_rr.bus_out, if_rr.grant, if_rr.bus_valid, if_rr.contention,
                if_rr.xfer_count, 8'h00, 4'b0000, 1'b0, 1'b0, 16'd0);
        @(posedge clk);
        #1;
        reset_n = 1'b1;

        // All four request for six cycles: rr rotates from 0, fixed stays on 0
        for (int i = 0; i < 6; i++) begin
            step();
            chk_all("rr_rot", if_rr.bus_out, if_rr.grant, if_rr.bus_valid, if_rr.contention,
                    if_rr.xfer_count, rr_bus[i], rr_seq[i], 1'b1, 1'b1, 16'(i + 1));
            chk_all("fix_all", if_fix.bus_out, if_fix.grant, if_fix.bus_valid, if_fix.contention,
                    if_fix.xfer_count, 8'h11, 4'b0001, 1'b1, 1'b1, 16'(i + 1));
        end

        // Long single-source run: counter saturates without wrapping
        tb_en_n = 4'b1110;
        repeat (65528) step();
        chk("sat_pre", {16'd0, if_fix.xfer_count}, 32'h0000FFFE);
        chk("sticky_cont", {31'd0, if_fix.contention}, 32'd1);
        step();
        chk("sat_hit", {16'd0, if_fix.xfer_count}, 32'h0000FFFF);
        repeat (4) step();
        chk("sat_hold_fix", {16'd0, if_fix.xfer_count}, 32'h0000FFFF);
        chk("sat_hold_rr", {16'd0, if_rr.xfer_count}, 32'h0000FFFF);
        chk("sat_gnt", {28'd0, if_fix.grant}, 32'h00000001);

        // Clear with only one requester
        tb_clr = 1'b1;
        step();
        chk("cont_clr", {31'd0, if_fix.contention}, 32'd0);
        tb_clr = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
